// File: rtl/mux5_sel_unit.sv
// -----------------------------------------------------------------------------
// mux5_sel_unit
//
// Purpose:
//   Five-way, single-output steering mux with a 3-bit select. Gives a
//   combinational result, a registered copy of it, a combinational
//   illegal-select flag, and a sticky registered version of that flag.
//
// Parameters:
//   WIDTH      - bit width of each input slot and of y / y_q.
//
// Ports:
//   clk        in   1          rising-edge system clock
//   rst_n      in   1          asynchronous active-low reset
//   i          in   5*WIDTH    packed slots; slot 0 is the MSB slot,
//                              slot k = i[(5-k)*WIDTH-1 : (4-k)*WIDTH]
//   s          in   3          select code, legal 0..4
//   clr_err    in   1          synchronous clear of err_sticky (wins over set)
//   y          out  WIDTH      combinational selected slot (0 on illegal s)
//   y_q        out  WIDTH      y registered, one cycle later
//   sel_err    out  1          combinational illegal-select flag (s >= 5)
//   err_sticky out  1          registered sticky illegal-select flag
//
// Handshake: none. New i / s are accepted every cycle; there is no
// valid/ready pair because the block is a pure per-cycle steering primitive.
// -----------------------------------------------------------------------------
module mux5_sel_unit #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5*WIDTH-1:0] i,
  input  logic [2:0]         s,
  input  logic               clr_err,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   y_q,
  output logic               sel_err,
  output logic               err_sticky
);

  logic [WIDTH-1:0] y_d;
  logic             sel_err_d;
  logic [WIDTH-1:0] y_reg_q;
  logic             err_sticky_d;
  logic             err_sticky_q;

  // Full decode of all eight select codes so no latch can be inferred and
  // codes 5..7 force a known all-zero result.
  always_comb begin
    y_d       = '0;
    sel_err_d = 1'b0;
    unique case (s)
      3'd0:    y_d = i[4*WIDTH +: WIDTH];
      3'd1:    y_d = i[3*WIDTH +: WIDTH];
      3'd2:    y_d = i[2*WIDTH +: WIDTH];
      3'd3:    y_d = i[1*WIDTH +: WIDTH];
      3'd4:    y_d = i[0*WIDTH +: WIDTH];
      default: begin
        y_d       = '0;
        sel_err_d = 1'b1;
      end
    endcase
  end

  // Clear takes priority over a simultaneous illegal select.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_sticky_d = 1'b0;
    end else if (sel_err_d) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg_q      <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      y_reg_q      <= y_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign y          = y_d;
  assign sel_err    = sel_err_d;
  assign y_q        = y_reg_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mux5_sel_unit.sv
module tb_mux5_sel_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; two instances (WIDTH=1 and WIDTH=4) see the same select.
  logic [2:0]  s       = 3'd2;
  logic        clr_err = 1'b0;
  logic [4:0]  i1      = 5'b11111;
  logic [19:0] i4      = 20'h0;

  logic        y1, yq1, se1, es1;
  logic [3:0]  y4, yq4;
  logic        se4, es4;

  mux5_sel_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .s(s), .clr_err(clr_err),
    .y(y1), .y_q(yq1), .sel_err(se1), .err_sticky(es1)
  );

  mux5_sel_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i(i4), .s(s), .clr_err(clr_err),
    .y(y4), .y_q(yq4), .sel_err(se4), .err_sticky(es4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: treat the bus as five slots numbered from the MSB end.
  // Slot k is the bus shifted right by (4-k)*w and masked to w bits.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] ref_sel(input logic [19:0] bus, input int w, input logic [2:0] sel);
    logic [19:0] t;
    int sh;
    if (int'(sel) > 4) return 4'h0;
    sh = (4 - int'(sel)) * w;
    t  = (bus >> sh) & ((20'd1 << w) - 20'd1);
    return t[3:0];
  endfunction

  function automatic logic ref_err(input logic [2:0] sel);
    return int'(sel) > 4;
  endfunction

  logic [3:0] exp_yq1, exp_yq4;
  logic       exp_sticky;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_yq1    <= 4'h0;
      exp_yq4    <= 4'h0;
      exp_sticky <= 1'b0;
    end else begin
      exp_yq1 <= ref_sel({15'b0, i1}, 1, s);
      exp_yq4 <= ref_sel(i4, 4, s);
      if (clr_err)          exp_sticky <= 1'b0;
      else if (ref_err(s))  exp_sticky <= 1'b1;
    end
  end

  // Compare process: every falling edge, away from the capture edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("y_w1",          {3'b0, y1},   ref_sel({15'b0, i1}, 1, s));
      check("sel_err_w1",    {3'b0, se1},  {3'b0, ref_err(s)});
      check("y_q_w1",        {3'b0, yq1},  exp_yq1);
      check("err_sticky_w1", {3'b0, es1},  {3'b0, exp_sticky});
      check("y_w4",          y4,           ref_sel(i4, 4, s));
      check("sel_err_w4",    {3'b0, se4},  {3'b0, ref_err(s)});
      check("y_q_w4",        yq4,          exp_yq4);
      check("err_sticky_w4", {3'b0, es4},  {3'b0, exp_sticky});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [2:0] ns, input logic [4:0] ni1, input logic nclr);
    @(posedge clk);
    #1;
    s       = ns;
    i1      = ni1;
    i4      = 20'($urandom);
    clr_err = nclr;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random stimulus with literal expectations
  // ---------------------------------------------------------------------------
  logic [4:0] walk_pat [5] = '{5'b10000, 5'b01000, 5'b11111, 5'b00010, 5'b00001};

  initial begin
    // Reset held with s=2, i=11111.
    repeat (2) @(posedge clk);
    #1;
    check("rst_y",          {3'b0, y1},  4'h1);
    check("rst_y_q",        {3'b0, yq1}, 4'h0);
    check("rst_err_sticky", {3'b0, es1}, 4'h0);
    rst_n = 1'b1;
    tick();
    check("rst_first_capture", {3'b0, yq1}, 4'h1);
    chk_en = 1'b1;

    // One-hot walk.
    for (int k = 0; k < 5; k++) begin
      step(3'(k), walk_pat[k], 1'b0);
      check("walk_y",       {3'b0, y1},  4'h1);
      check("walk_sel_err", {3'b0, se1}, 4'h0);
      tick();
      check("walk_y_q",     {3'b0, yq1}, 4'h1);
    end

    // Unselected-bit isolation.
    step(3'd0, 5'b01111, 1'b0);
    check("iso0_y",       {3'b0, y1},  4'h0);
    check("iso0_sel_err", {3'b0, se1}, 4'h0);
    step(3'd4, 5'b11110, 1'b0);
    check("iso4_y",       {3'b0, y1},  4'h0);
    check("iso4_sel_err", {3'b0, se1}, 4'h0);

    // Illegal select and stickiness.
    step(3'd5, 5'b11111, 1'b0);
    check("ill_y",       {3'b0, y1},  4'h0);
    check("ill_y_w4",    y4,          4'h0);
    check("ill_sel_err", {3'b0, se1}, 4'h1);
    tick();
    check("ill_sticky_set", {3'b0, es1}, 4'h1);
    step(3'd2, 5'b00000, 1'b0);
    tick();
    check("ill_sticky_hold", {3'b0, es1}, 4'h1);

    // Clear beats a simultaneous illegal select.
    step(3'd6, 5'b10101, 1'b1);
    tick();
    check("clr_priority", {3'b0, es1}, 4'h0);
    clr_err = 1'b0;
    tick();
    check("clr_reset_again", {3'b0, es1}, 4'h1);

    // Async reset between edges.
    step(3'd0, 5'b10000, 1'b0);
    tick();
    check("pre_arst_y_q",   {3'b0, yq1}, 4'h1);
    check("pre_arst_stick", {3'b0, es1}, 4'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_y_q",      {3'b0, yq1}, 4'h0);
    check("arst_sticky",   {3'b0, es1}, 4'h0);
    check("arst_y_q_w4",   yq4,         4'h0);
    check("arst_y_live",   {3'b0, y1},  4'h1);
    rst_n = 1'b1;

    // Randomized run; the compare process checks every falling edge.
    for (int n = 0; n < 400; n++) begin
      step(3'($urandom_range(0, 7)), 5'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("rand_arst_y_q",    {3'b0, yq1}, 4'h0);
        check("rand_arst_sticky", {3'b0, es4}, 4'h0);
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
